// File: rtl/pc_sequencer.sv
// pc_sequencer: IF-stage controller choosing the next PC (hold / increment / redirect),
// flagging valid fetches, flushing IF/ID on redirects and counting fetched instructions.
module pc_sequencer #(
    parameter int           N            = 32,
    parameter int           INSTR_BYTES  = 4,
    parameter logic [N-1:0] RESET_PC     = '0,
    parameter int           FLUSH_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] pc_q,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         halt_req,
    output logic [N-1:0] pc_next,
    output logic         if_valid,
    output logic         flush_o,
    output logic         halted,
    output logic         misaligned,
    output logic [31:0]  fetch_count
);
    localparam int           ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [N-1:0] INC        = N'(INSTR_BYTES);
    localparam logic [2:0]   BUBBLES    = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {IDLE, FETCH, REDIRECT, HALT} state_t;

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       set_mis;
    logic       count_en;
    logic       target_ok;

    assign target_ok = branch_target[ALIGN_BITS-1:0] == '0;
    assign halted    = state == HALT;

    // next-state and combinational fetch outputs; priority halt > branch > stall > sequential
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_next  = pc_q;
        if_valid = 1'b0;
        flush_o  = 1'b0;
        set_mis  = 1'b0;
        count_en = 1'b0;
        case (state)
            IDLE: begin
                pc_next  = RESET_PC;
                state_nx = start ? FETCH : IDLE;
            end
            FETCH: begin
                if (halt_req) begin
                    flush_o  = 1'b1;
                    state_nx = HALT;
                end else if (branch_taken) begin
                    flush_o = 1'b1;
                    if (target_ok) begin
                        pc_next  = branch_target;
                        cnt_nx   = BUBBLES;
                        state_nx = REDIRECT;
                    end else begin
                        set_mis  = 1'b1;
                        state_nx = HALT;
                    end
                end else begin
                    if_valid = 1'b1;
                    if (!stall) begin
                        pc_next  = pc_q + INC;
                        count_en = 1'b1;
                    end
                end
            end
            REDIRECT: begin
                if (halt_req) begin
                    state_nx = HALT;
                end else begin
                    cnt_nx   = cnt - 3'd1;
                    state_nx = (cnt <= 3'd1) ? FETCH : REDIRECT;
                end
            end
            default: state_nx = HALT;
        endcase
    end

    // state register and bubble counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misaligned <= 1'b0;
        else if (set_mis)
            misaligned <= 1'b1;
    end

    // saturating count of accepted sequential fetches
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_count <= 32'd0;
        else if (count_en && fetch_count != 32'hFFFF_FFFF)
            fetch_count <= fetch_count + 32'd1;
    end
endmodule
